// File: rtl/safe_alu.sv
// safe_alu: registered two-operand ALU (ADD/SUB/AND/OR) with zero, carry/borrow
// and signed-overflow flags, plus a sticky overflow flag that is held until
// explicitly cleared.
//
// Handshake: the block has no backpressure. A cycle with in_valid=1 is
// accepted unconditionally on the next rising edge, and its result is
// presented with out_valid=1 for exactly the following cycle. r/z/c/v hold
// their last value while out_valid=0. rst discards any operation offered in
// the same cycle.
module safe_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             clr_sticky,
  output logic             out_valid,
  output logic [WIDTH-1:0] r,
  output logic             z,
  output logic             c,
  output logic             v,
  output logic             sticky_v
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

  localparam int MSB = WIDTH - 1;

  // Extended-width sum/difference: bit WIDTH is carry for ADD and borrow for SUB.
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [WIDTH-1:0] r_next;
  logic             c_next;
  logic             v_next;
  logic             z_next;

  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};

  // Next result and flags for the offered operation; wrapping, never saturating.
  always_comb begin
    r_next = '0;
    c_next = 1'b0;
    v_next = 1'b0;
    unique case (op_e'(op))
      OP_ADD: begin
        r_next = sum_ext[WIDTH-1:0];
        c_next = sum_ext[WIDTH];
        v_next = (a[MSB] == b[MSB]) && (sum_ext[MSB] != a[MSB]);
      end
      OP_SUB: begin
        r_next = diff_ext[WIDTH-1:0];
        c_next = diff_ext[WIDTH];
        v_next = (a[MSB] != b[MSB]) && (diff_ext[MSB] != a[MSB]);
      end
      OP_AND: r_next = a & b;
      OP_OR:  r_next = a | b;
      default: r_next = '0;
    endcase
    z_next = (r_next == '0);
  end

  // Output registers: capture on accepted cycles, hold otherwise; reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      r         <= '0;
      z         <= 1'b0;
      c         <= 1'b0;
      v         <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        r <= r_next;
        z <= z_next;
        c <= c_next;
        v <= v_next;
      end
    end
  end

  // Sticky overflow: a newly registered v=1 takes priority over a clear request.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_v <= 1'b0;
    end else if (in_valid && v_next) begin
      sticky_v <= 1'b1;
    end else if (clr_sticky) begin
      sticky_v <= 1'b0;
    end
  end

endmodule

// File: tb/tb_safe_alu.sv
// tb_safe_alu: directed vectors for safe_alu. The driver pushes each
// hand-computed result into exp_q; the monitor pops and compares whenever
// out_valid is seen, and checks held outputs and sticky_v on every cycle.
module tb_safe_alu;

  localparam int W  = 8;
  localparam int EW = W + 3; // {r, z, c, v}

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] AND = 2'b10;
  localparam logic [1:0] OR  = 2'b11;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [1:0]   op = 2'b00;
  logic         clr_sticky = 1'b0;
  logic         out_valid;
  logic [W-1:0] r;
  logic         z;
  logic         c;
  logic         v;
  logic         sticky_v;

  // Scoreboard state
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] pend = '0;
  logic [EW-1:0] exp_hold = '0;
  logic          exp_sticky = 1'b0;
  int            checks = 0;
  int            errors = 0;

  safe_alu #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .a(a),
    .b(b),
    .op(op),
    .clr_sticky(clr_sticky),
    .out_valid(out_valid),
    .r(r),
    .z(z),
    .c(c),
    .v(v),
    .sticky_v(sticky_v)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one edge and update the reference for held outputs and sticky_v.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      exp_hold   = '0;
      exp_sticky = 1'b0;
    end else begin
      if (in_valid) exp_hold = pend;
      if (in_valid && pend[0]) exp_sticky = 1'b1;
      else if (clr_sticky)     exp_sticky = 1'b0;
    end
    #1;
  endtask

  // Offer one operation for one cycle with its hand-computed result.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] er, input logic ez, input logic ec, input logic ev);
    op       = o;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    pend     = {er, ez, ec, ev};
    exp_q.push_back(pend);
    step();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  // Monitor: compare at the falling edge, away from the active edge.
  initial begin
    logic [EW-1:0] e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid: got out_valid=1 required 0 (t=%0t)", $time);
        end else begin
          e = exp_q.pop_front();
          check("result", {r, z, c, v}, e);
        end
      end else begin
        check("hold", {r, z, c, v}, exp_hold);
      end
      check("sticky_v", {{(EW-1){1'b0}}, sticky_v}, {{(EW-1){1'b0}}, exp_sticky});
    end
  end

  // Driver
  initial begin
    // Reset for a few cycles: all outputs zero, no out_valid.
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(1);

    // Back-to-back ADDs: one result per cycle, in order.
    issue(ADD, 8'd10,  8'd20,  8'd30,  1'b0, 1'b0, 1'b0);
    issue(ADD, 8'd200, 8'd100, 8'd44,  1'b0, 1'b1, 1'b0);
    issue(ADD, 8'd0,   8'd0,   8'd0,   1'b1, 1'b0, 1'b0);
    idle(2);

    // Signed overflow on ADD sets sticky_v; it stays set while idle.
    issue(ADD, 8'h7F,  8'h01,  8'h80,  1'b0, 1'b0, 1'b1);
    idle(3);

    // Clear sticky for one cycle.
    clr_sticky = 1'b1;
    step();
    clr_sticky = 1'b0;
    idle(1);

    // Wrap to zero with carry.
    issue(ADD, 8'hFF,  8'h01,  8'h00,  1'b1, 1'b1, 1'b0);
    // SUB cases.
    issue(SUB, 8'd50,  8'd10,  8'd40,  1'b0, 1'b0, 1'b0);
    issue(SUB, 8'd10,  8'd50,  8'hD8,  1'b0, 1'b1, 1'b0);
    issue(SUB, 8'd5,   8'd5,   8'd0,   1'b1, 1'b0, 1'b0);
    idle(1);
    // Logic ops.
    issue(AND, 8'hAA,  8'h0F,  8'h0A,  1'b0, 1'b0, 1'b0);
    issue(OR,  8'h55,  8'h88,  8'hDD,  1'b0, 1'b0, 1'b0);
    issue(AND, 8'hF0,  8'h0F,  8'h00,  1'b1, 1'b0, 1'b0);
    idle(2);

    // SUB overflow together with clr_sticky: set wins.
    clr_sticky = 1'b1;
    issue(SUB, 8'h80,  8'h01,  8'h7F,  1'b0, 1'b0, 1'b1);
    clr_sticky = 1'b0;
    idle(2);

    // Reset while an operation is offered: it is discarded, everything zero.
    op       = ADD;
    a        = 8'h7F;
    b        = 8'h7F;
    in_valid = 1'b1;
    rst      = 1'b1;
    step();
    rst      = 1'b0;
    idle(3);

    // First operation after reset completes with normal latency.
    issue(OR,  8'h01,  8'h02,  8'h03,  1'b0, 1'b0, 1'b0);
    idle(3);

    // Every expected result must have been consumed.
    check("queue_empty", EW'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
